core_seq: RTL
=============

Name: core_seq

Overview:
- Instruction sequencer that acts as the initiator driving one attention core over its 17-bit `inst` bus and its `mem_in` data bus.
- Accepts a start pulse and a valid/ready stream of Q rows followed by K rows.
- Issues the full instruction schedule in order: Q write, K write, kernel load, execute, OFIFO drain into PSUM memory, then PSUM readback.
- Flags each PSUM row as it appears on the core's `out` bus, and pulses `done` at the end.

Parameters:
- bw, 8, bits per activation element
- pr, 8, elements per Q/K row (mem_in width = pr*bw)
- col, 8, MAC array columns; number of K rows loaded into the array
- len, 8, number of Q rows executed (1..16)
- gap_cyc, 2, idle bubble cycles between kernel load and execute
- drain_cyc, 12, wait cycles after last execute before OFIFO reads start (1..63)
- fifo_lat, 1, cycles from ofifo_rd to OFIFO data valid at PSUM mem input (0..3)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- start  in  1  single-cycle request; sampled only in IDLE
- in_data  in  pr*bw  Q/K row stream
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts row; transfer when in_valid&&in_ready
- mem_in  out  pr*bw  registered row to core Q/K memories
- inst  out  17  registered core instruction (encoding below)
- out_valid  out  1  core out bus holds PSUM row out_addr this cycle
- out_addr  out  4  PSUM row index for out_valid
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last readback row

Behaviour:
- inst fields:
  - [16] ofifo_rd
  - [15:12] qkmem_add
  - [11:8] pmem_add
  - [7] execute
  - [6] kernel load (selects kmem onto array)
  - [5] qmem_rd, [4] qmem_wr
  - [3] kmem_rd, [2] kmem_wr
  - [1] pmem_rd, [0] pmem_wr
- Reset: inst=0, mem_in=0, in_ready=0, out_valid=0, out_addr=0, busy=0, done=0; state IDLE; all counters 0. Reset asserted mid-operation aborts immediately with the same values; no partial completion.
- inst and mem_in are registered. Any unused field is 0. In any cycle with no action, inst=0.
- States:
  - IDLE: start=1 -> QWR, row counter=0. start while busy is ignored.
  - QWR: in_ready=1. Each accepted row i (0..len-1) produces next cycle mem_in=row, inst[4]=1, qkmem_add=i. If in_valid=0, next inst=0 (stall); no timeout. After row len-1 is accepted -> KWR.
  - KWR: same as QWR using inst[2], rows 0..col-1. After row col-1 -> KLD. in_ready is 0 from KLD onward.
  - KLD: col cycles with inst[6]=1, inst[3]=1, qkmem_add=0..col-1. Then one extra cycle with inst[6]=1 only (flush). -> GAP.
  - GAP: gap_cyc cycles, inst=0. -> EXE.
  - EXE: len cycles with inst[7]=1, inst[5]=1, qkmem_add=0..len-1. -> DRN.
  - DRN: drain_cyc cycles, inst=0. -> OFR.
  - OFR: len cycles with inst[16]=1. The pmem_wr for row j is issued exactly fifo_lat cycles after the j-th ofifo_rd, with pmem_add=j. It may overlap later ofifo_rd cycles in the same inst word. With fifo_lat=0, both bits share a cycle. Stay in OFR until the last pmem_wr is issued. -> PRD.
  - PRD: len cycles with inst[1]=1, pmem_add=0..len-1. out_valid=1 with out_addr=k exactly one cycle after the inst word carrying pmem_add=k, matching single-cycle SRAM read latency. -> FIN after the last out_valid.
  - FIN: done=1 for one cycle, busy=0 next cycle; -> IDLE.
- Address counters are 4 bits. len=16 uses addresses 0..15 with no wrap before the phase ends.
- No in_data is accepted outside QWR/KWR. Extra rows stay pending upstream.
- Total cycles from start to done with no stalls: 2 + len + col + (col+1) + gap_cyc + len + drain_cyc + len + fifo_lat + len + 1. Verify against the counter implementation; the bench checks the exact value.

Test Plan:
- Defaults, rows always valid, start -> exact inst sequence:
  - 8 qmem writes at addrs 0..7, then 8 kmem writes
  - 9 load cycles (last cycle 0x00040 only), 2 zero cycles
  - 8 execute words 0x000A0 | (addr<<12)
  - 12 zeros, 8 ofifo_rd, pmem_wr addrs 0..7 one cycle behind
  - 8 pmem_rd, out_valid/out_addr 0..7, single done pulse
- in_valid toggled 1,0,1,0 during QWR -> inst=0 in stall cycles; qkmem_add still counts 0..7 with no skips; mem_in matches accepted data.
- fifo_lat=0 and fifo_lat=3 -> ofifo_rd-to-pmem_wr spacing is 0 and 3 cycles; exactly len pmem_wr with addrs 0..len-1.
- len=16 -> execute addrs 0..15, out_addr reaches 15, no wrap to 0.
- reset driven low during EXE -> all outputs 0 within the same cycle (async). After release, start restarts from QWR with addr 0.
- start pulsed during DRN, and start held high at done -> no effect mid-run; a new run begins only on the IDLE sample after done.

Source files
------------

// File: rtl/core_seq.sv
// Instruction sequencer for one attention core: loads Q/K rows, then walks the
// fixed kernel-load / execute / OFIFO-drain / PSUM-readback schedule.
`timescale 1ns/1ps
module core_seq #(
  parameter int bw        = 8,
  parameter int pr        = 8,
  parameter int col       = 8,
  parameter int len       = 8,
  parameter int gap_cyc   = 2,
  parameter int drain_cyc = 12,
  parameter int fifo_lat  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [pr*bw-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [pr*bw-1:0] mem_in,
  output logic [16:0]      inst,
  output logic             out_valid,
  output logic [3:0]       out_addr,
  output logic             busy,
  output logic             done,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    IDLE, QWR, KWR, KLD, GAP, EXE, DRN, OFR, PRD, FIN
  } state_t;

  // Wide enough for drain_cyc up to 63 and len + fifo_lat / len + 1 phase spans.
  localparam int cw = 7;

  state_t           state, state_nxt;
  logic [cw-1:0]    cnt, cnt_nxt;
  logic [16:0]      inst_nxt;
  logic [pr*bw-1:0] mem_nxt;
  logic             take;

  // A row transfers only on a cycle where in_valid && in_ready; in_ready
  // depends on state alone, never on in_valid.
  assign in_ready  = (state == QWR) || (state == KWR);
  assign take      = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    inst_nxt  = '0;
    mem_nxt   = mem_in;
    case (state)
      IDLE: if (start) begin
        state_nxt = QWR;
        cnt_nxt   = '0;
      end
      QWR: if (take) begin
        inst_nxt[4]     = 1'b1;
        inst_nxt[15:12] = cnt[3:0];
        mem_nxt         = in_data;
        if (cnt == cw'(len - 1)) begin
          state_nxt = KWR;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + 1'b1;
      end
      KWR: if (take) begin
        inst_nxt[2]     = 1'b1;
        inst_nxt[15:12] = cnt[3:0];
        mem_nxt         = in_data;
        if (cnt == cw'(col - 1)) begin
          state_nxt = KLD;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + 1'b1;
      end
      KLD: begin
        inst_nxt[6] = 1'b1;
        // Final load cycle keeps the load strobe but stops reading kmem.
        if (cnt == cw'(col)) begin
          state_nxt = (gap_cyc == 0) ? EXE : GAP;
          cnt_nxt   = '0;
        end else begin
          inst_nxt[3]     = 1'b1;
          inst_nxt[15:12] = cnt[3:0];
          cnt_nxt         = cnt + 1'b1;
        end
      end
      GAP: if (cnt == cw'(gap_cyc - 1)) begin
        state_nxt = EXE;
        cnt_nxt   = '0;
      end else cnt_nxt = cnt + 1'b1;
      EXE: begin
        inst_nxt[7]     = 1'b1;
        inst_nxt[5]     = 1'b1;
        inst_nxt[15:12] = cnt[3:0];
        if (cnt == cw'(len - 1)) begin
          state_nxt = DRN;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + 1'b1;
      end
      DRN: if (cnt == cw'(drain_cyc - 1)) begin
        state_nxt = OFR;
        cnt_nxt   = '0;
      end else cnt_nxt = cnt + 1'b1;
      OFR: begin
        // PSUM write trails each OFIFO read by fifo_lat cycles.
        if (cnt < cw'(len)) inst_nxt[16] = 1'b1;
        if (cnt >= cw'(fifo_lat)) begin
          inst_nxt[0]    = 1'b1;
          inst_nxt[11:8] = cnt[3:0] - 4'(fifo_lat);
        end
        if (cnt == cw'(len + fifo_lat - 1)) begin
          state_nxt = PRD;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + 1'b1;
      end
      PRD: begin
        // Two trailing cycles cover inst register plus SRAM read latency.
        if (cnt < cw'(len)) begin
          inst_nxt[1]    = 1'b1;
          inst_nxt[11:8] = cnt[3:0];
        end
        if (cnt == cw'(len + 1)) begin
          state_nxt = FIN;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + 1'b1;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      inst      <= '0;
      mem_in    <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      inst      <= inst_nxt;
      mem_in    <= mem_nxt;
      out_valid <= inst[1];
      out_addr  <= inst[1] ? inst[11:8] : 4'd0;
    end
  end

endmodule
